btn_debounce_onepulse: RTL and testbench
========================================

// Module: btn_debounce_onepulse
// PURPOSE
//  Conditions one raw push-button input before the long-press reset detector and the control FSMs.
//  - 2-FF synchronizer, then a sampled-majority-free debouncer (N identical samples required).
//  - btn_level drives the long-press counter's trigger input.
//  - press_pulse / release_pulse give single-clk events for short-press control (start/pause, mode).
// PARAMETERS
//  SYNC_STAGES  2       synchronizer depth, >=2
//  TICK_DIV     100000  clk cycles per debounce sample (sample_tick period), >=1
//  DB_SAMPLES   4       consecutive identical samples needed to change btn_level, >=2
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  reset, asynchronous, active-low
//  btn_raw        in   1  raw asynchronous button, 1 = pressed
//  btn_level      out  1  debounced level, 1 = pressed; feeds long-press detector input
//  press_pulse    out  1  one-clk pulse on debounced 0->1
//  release_pulse  out  1  one-clk pulse on debounced 1->0
//  sample_tick    out  1  one-clk enable every TICK_DIV clks (exported for other slow logic)
// BEHAVIOUR
//  Reset (async, rst_n=0): sync flops, shift reg, tick counter, btn_level, level_d all 0;
//   all outputs 0 while rst_n=0 and on the first clk after release.
//  Synchronizer: btn_sync = btn_raw delayed SYNC_STAGES clk edges; no other logic on raw input.
//  Tick divider: tick_cnt counts 0..TICK_DIV-1, wraps to 0; sample_tick = (tick_cnt==TICK_DIV-1).
//   First tick is the TICK_DIV-th clk after reset release. TICK_DIV=1 -> sample_tick constantly 1.
//   Counter width = clog2(TICK_DIV), min 1; wrap is explicit compare, not overflow.
//  Debounce (only on sample_tick=1; otherwise hold everything):
//   win = {sr[DB_SAMPLES-2:0], btn_sync}; sr <= win[DB_SAMPLES-2:0].
//   FSM, state == btn_level:
//    RELEASED(0): win all ones  -> PRESSED  on the same edge; else stay.
//    PRESSED(1) : win all zeros -> RELEASED on the same edge; else stay.
//   Mixed window (bounce) never changes state.
//  Latency raw rise -> btn_level rise: SYNC_STAGES + (DB_SAMPLES-1)*TICK_DIV + 1 clks minimum,
//   SYNC_STAGES + DB_SAMPLES*TICK_DIV clks maximum (stable input). Same bounds for release.
//  Edge pulses: level_d <= btn_level every clk.
//   press_pulse   = btn_level & ~level_d  (high exactly in the first clk btn_level is 1)
//   release_pulse = ~btn_level & level_d
//   Never both high; at most one of each per debounced transition.
//  Glitch narrower than TICK_DIV clks that falls between ticks: invisible.
//   Sampled once: rejected by window.
//  Reset mid-press: outputs drop to 0 asynchronously, no release_pulse.
//   If button still held after release of rst_n, a fresh press_pulse follows after full latency.
//  Held button: btn_level stays 1 indefinitely; no repeat pulses (long-press handled downstream).
// TESTING (bench: SYNC_STAGES=2, TICK_DIV=4, DB_SAMPLES=4)
//  1 Reset release, btn_raw=0 -> all outputs 0; sample_tick high on clk 4, 8, 12 ... exactly 1 clk each.
//  2 btn_raw 0->1 held 60 clks -> btn_level rises 15..18 clks later.
//    press_pulse high exactly 1 clk, coincident with rise.
//  3 btn_raw toggles every 3 clks for 30 clks, then stays 1 -> no press_pulse during bounce.
//    Exactly one press_pulse after steady 1.
//  4 From pressed, btn_raw 1->0 held -> btn_level falls 15..18 clks later.
//    release_pulse 1 clk; press_pulse stays 0.
//  5 btn_raw 1-clk high pulse every 20 clks for 200 clks -> btn_level never rises, no pulses.
//  6 Button held, btn_level=1, rst_n low 3 clks mid-operation -> outputs 0 immediately, no release_pulse.
//    After rst_n high, one press_pulse 15..18 clks later.

Source files
------------

// File: rtl/btn_debounce_onepulse.sv
// Push-button conditioner: input synchronizer, tick-paced N-sample debouncer,
// and single-clock press/release event pulses derived from the debounced level.
module btn_debounce_onepulse #(
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 100000,
  parameter int DB_SAMPLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic sample_tick
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [0:0] RELEASED = 1'b0;
  localparam logic [0:0] PRESSED  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [CNT_W-1:0]       tick_cnt;
  logic [DB_SAMPLES-2:0]  sr;
  logic [DB_SAMPLES-1:0]  win;
  logic [0:0]             state;
  logic [0:0]             state_nxt;
  logic                   level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Explicit wrap compare so non-power-of-two dividers keep an exact period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);

  // Window is the last DB_SAMPLES-1 stored samples plus the current one.
  assign win = {sr, btn_sync};

  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RELEASED: if (&win)  state_nxt = PRESSED;
      PRESSED:  if (~|win) state_nxt = RELEASED;
      default:  state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      sr    <= '0;
    end else if (sample_tick) begin
      state <= state_nxt;
      sr    <= win[DB_SAMPLES-2:0];
    end
  end

  // Delayed copy of the level; reset to 0 so an async reset mid-press never
  // produces a release event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= state[0];
    end
  end

  assign btn_level     = state[0];
  assign press_pulse   = state[0] & ~level_d;
  assign release_pulse = ~state[0] & level_d;

endmodule

// File: tb/tb_btn_debounce_onepulse.sv
// Self-checking bench for btn_debounce_onepulse: tick/reset table, directed
// press/release/bounce/glitch/reset sequences, and random stimulus vs a model.
module tb_btn_debounce_onepulse;

  localparam int SYNC = 2;
  localparam int TD   = 4;
  localparam int DB   = 4;
  localparam int LAT_MIN = SYNC + (DB - 1) * TD + 1;
  localparam int LAT_MAX = SYNC + DB * TD;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, sample_tick;

  btn_debounce_onepulse #(
    .SYNC_STAGES(SYNC),
    .TICK_DIV   (TD),
    .DB_SAMPLES (DB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .sample_tick  (sample_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: raw value is seen SYNC edges later; every TD-th edge a
  // sample is taken and the level follows only a window of DB equal samples.
  bit m_sync[$];
  bit m_hist[$];
  int m_cnt     = 0;
  bit m_level   = 1'b0;
  bit m_level_d = 1'b0;
  bit m_cur, m_all1, m_all0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = {};
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
      for (int i = 0; i < DB - 1; i++) m_hist.push_back(1'b0);
      m_cnt     = 0;
      m_level   = 1'b0;
      m_level_d = 1'b0;
    end else begin
      m_cur     = m_sync[0];
      m_level_d = m_level;
      if ((m_cnt % TD) == TD - 1) begin
        m_all1 = m_cur;
        m_all0 = !m_cur;
        foreach (m_hist[i]) begin
          m_all1 &= m_hist[i];
          m_all0 &= !m_hist[i];
        end
        if (m_all1) m_level = 1'b1;
        else if (m_all0) m_level = 1'b0;
        m_hist.push_back(m_cur);
        void'(m_hist.pop_front());
      end
      m_sync.push_back(btn_raw);
      void'(m_sync.pop_front());
      m_cnt++;
    end
  end

  // Continuous comparison against the model, plus event counters.
  bit chk_on    = 1'b0;
  int press_cnt = 0;
  int rel_cnt   = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_level",   btn_level,     m_level);
      check("m_press",   press_pulse,   m_level & ~m_level_d);
      check("m_release", release_pulse, ~m_level & m_level_d);
      check("m_tick",    sample_tick,   (rst_n && (m_cnt % TD) == TD - 1));
      check("pulse_excl", press_pulse & release_pulse, 1'b0);
    end
    if (press_pulse) press_cnt++;
    if (release_pulse) rel_cnt++;
  end

  // Inputs change 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_level(input logic val, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (btn_level === val) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic raw;
    logic exp_tick;
    logic exp_level;
  } vec_t;

  vec_t vecs[12];
  int   lat, p0, r0;
  logic seen_level;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    repeat (3) step();
    check("rst_level",   btn_level,     1'b0);
    check("rst_press",   press_pulse,   1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_tick",    sample_tick,   1'b0);

    // Test 1: tick cadence after reset release with the button idle.
    for (int i = 0; i < 12; i++) begin
      vecs[i].raw       = 1'b0;
      vecs[i].exp_tick  = ((i + 1) % TD == TD - 1);
      vecs[i].exp_level = 1'b0;
    end
    rst_n  = 1'b1;
    chk_on = 1'b1;
    #1;
    check("rel_level", btn_level,   1'b0);
    check("rel_tick",  sample_tick, 1'b0);
    for (int i = 0; i < 12; i++) begin
      btn_raw = vecs[i].raw;
      step();
      check("tbl_tick",  sample_tick, vecs[i].exp_tick);
      check("tbl_level", btn_level,   vecs[i].exp_level);
      check("tbl_press", press_pulse, 1'b0);
    end

    // Test 2: clean press held 60 clocks.
    p0 = press_cnt;
    btn_raw = 1'b1;
    wait_level(1'b1, lat);
    check_rng("press_latency", lat, LAT_MIN, LAT_MAX);
    check("press_pulse_at_rise", press_pulse, 1'b1);
    step();
    check("press_pulse_one_clk", press_pulse, 1'b0);
    repeat (60 - ((lat < 0) ? 0 : lat) - 1) step();
    check("held_level", btn_level, 1'b1);
    check("press_count", press_cnt - p0, 1);

    // Test 4: release from pressed.
    p0 = press_cnt;
    r0 = rel_cnt;
    btn_raw = 1'b0;
    wait_level(1'b0, lat);
    check_rng("release_latency", lat, LAT_MIN, LAT_MAX);
    check("release_pulse_at_fall", release_pulse, 1'b1);
    step();
    check("release_pulse_one_clk", release_pulse, 1'b0);
    repeat (20) step();
    check("release_count", rel_cnt - r0, 1);
    check("no_press_on_release", press_cnt - p0, 0);

    // Test 3: bouncing input then steady press.
    p0 = press_cnt;
    for (int i = 0; i < 30; i++) begin
      btn_raw = ((i / 3) % 2 == 0);
      step();
    end
    check("bounce_no_press", press_cnt - p0, 0);
    btn_raw = 1'b1;
    wait_level(1'b1, lat);
    check_rng("bounce_settle_rise", lat, 1, LAT_MAX);
    repeat (30) step();
    check("bounce_one_press", press_cnt - p0, 1);

    btn_raw = 1'b0;
    wait_level(1'b0, lat);
    repeat (20) step();

    // Test 5: isolated 1-clock glitches are rejected.
    p0 = press_cnt;
    r0 = rel_cnt;
    seen_level = 1'b0;
    for (int i = 0; i < 200; i++) begin
      btn_raw = (i % 20 == 0);
      step();
      seen_level |= btn_level;
    end
    btn_raw = 1'b0;
    check("glitch_level", seen_level, 1'b0);
    check("glitch_press", press_cnt - p0, 0);
    check("glitch_release", rel_cnt - r0, 0);

    // Test 6: reset while held.
    btn_raw = 1'b1;
    wait_level(1'b1, lat);
    repeat (10) step();
    r0 = rel_cnt;
    p0 = press_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_level",   btn_level,     1'b0);
    check("rst_mid_press",   press_pulse,   1'b0);
    check("rst_mid_release", release_pulse, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_level(1'b1, lat);
    check_rng("rst_repress_latency", lat, LAT_MIN, LAT_MAX);
    check("rst_repress_pulse", press_pulse, 1'b1);
    repeat (10) step();
    check("rst_no_release", rel_cnt - r0, 0);
    check("rst_one_press", press_cnt - p0, 1);

    // Random stimulus against the model.
    for (int h = 0; h < 300; h++) begin
      btn_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) step();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
